// File: rtl/mem_dp_cfg_pkg.sv
// Shared types and constants for the configurable simple-dual-port memory.
package mem_dp_cfg_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/mem_dp_cfg_array.sv
// Plain storage array: one write port, one registered read port with
// selectable same-address read-during-write behaviour.
module mem_dp_cfg_array
  import mem_dp_cfg_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int RDW_MODE = RDW_OLD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              bypass;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Forward the incoming word only when the new-data policy is selected.
  assign bypass = (RDW_MODE == RDW_NEW) && we && (waddr == raddr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= bypass ? wdata : mem[raddr];
  end

endmodule

// File: rtl/mem_dp_cfg.sv
// Configurable simple-dual-port memory with read-valid flag, optional output
// register and a self-timed zero-fill clear engine.
module mem_dp_cfg
  import mem_dp_cfg_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = RDW_OLD
) (
  input  logic              mem_dp_cfg_clk,
  input  logic              mem_dp_cfg_rst_n,
  input  logic [ADDR_W-1:0] mem_dp_cfg_waddr,
  input  logic              mem_dp_cfg_wen,
  input  logic [DATA_W-1:0] mem_dp_cfg_data_in,
  input  logic [ADDR_W-1:0] mem_dp_cfg_raddr,
  input  logic              mem_dp_cfg_ren,
  input  logic              mem_dp_cfg_clear,
  output logic [DATA_W-1:0] mem_dp_cfg_data_out,
  output logic              mem_dp_cfg_rvalid,
  output logic              mem_dp_cfg_busy
);

  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              arr_we;
  logic              arr_re;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] rdata_p1;
  logic              vld_p1;

  always_ff @(posedge mem_dp_cfg_clk or negedge mem_dp_cfg_rst_n) begin
    if (!mem_dp_cfg_rst_n) state <= ST_IDLE;
    else                   state <= state_nxt;
  end

  // Counter wraps back to 0 after the last address, ready for the next clear.
  always_ff @(posedge mem_dp_cfg_clk or negedge mem_dp_cfg_rst_n) begin
    if (!mem_dp_cfg_rst_n)      clr_cnt <= '0;
    else if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (mem_dp_cfg_clear)     state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_cnt == LAST_ADDR) state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  // The clear engine owns the write port and blocks user reads while active.
  always_comb begin
    mem_dp_cfg_busy = 1'b0;
    arr_we          = mem_dp_cfg_wen;
    arr_waddr       = mem_dp_cfg_waddr;
    arr_wdata       = mem_dp_cfg_data_in;
    arr_re          = mem_dp_cfg_ren;
    if (state == ST_CLEAR) begin
      mem_dp_cfg_busy = 1'b1;
      arr_we          = 1'b1;
      arr_waddr       = clr_cnt;
      arr_wdata       = '0;
      arr_re          = 1'b0;
    end
  end

  mem_dp_cfg_array #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RDW_MODE (RDW_MODE)
  ) u_array (
    .clk   (mem_dp_cfg_clk),
    .rst_n (mem_dp_cfg_rst_n),
    .waddr (arr_waddr),
    .we    (arr_we),
    .wdata (arr_wdata),
    .raddr (mem_dp_cfg_raddr),
    .re    (arr_re),
    .rdata (rdata_p1)
  );

  // Stage 1: array read register and its valid flag
  always_ff @(posedge mem_dp_cfg_clk or negedge mem_dp_cfg_rst_n) begin
    if (!mem_dp_cfg_rst_n) vld_p1 <= 1'b0;
    else                   vld_p1 <= arr_re;
  end

  // Stage 2: optional output register, loaded only by a valid read
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] data_p2;
      logic              vld_p2;

      always_ff @(posedge mem_dp_cfg_clk or negedge mem_dp_cfg_rst_n) begin
        if (!mem_dp_cfg_rst_n) begin
          data_p2 <= '0;
          vld_p2  <= 1'b0;
        end else begin
          vld_p2 <= vld_p1;
          if (vld_p1) data_p2 <= rdata_p1;
        end
      end

      assign mem_dp_cfg_data_out = data_p2;
      assign mem_dp_cfg_rvalid   = vld_p2;
    end else begin : g_no_out_reg
      assign mem_dp_cfg_data_out = rdata_p1;
      assign mem_dp_cfg_rvalid   = vld_p1;
    end
  endgenerate

endmodule
